systolic_array_os_drain: RTL and testbench
==========================================

Name: systolic_array_os_drain

Overview:
- Output-side collector downstream of the output-stationary systolic array's last PE row.
- During a flush, each column's bottom PE emits NUM_ROW accumulated results. Columns are skewed by one cycle per column index.
- The block captures these per-column streams into small per-column FIFOs, deskews them, and presents one full row (NUM_COL results) per beat on a valid/ready write port to the output SRAM writer.
- It tracks the row index and signals completion of the tile.

Parameters:
- NUM_COL, 4, number of array columns.
- NUM_ROW, 4, number of array rows, i.e. results per column per flush.
- SA_OUT_DATA_WIDTH, 32, width of one accumulated result.
- FIFO_DEPTH, 8, entries per column FIFO; power of two, at least NUM_COL.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle pulse; arms the block for a new tile flush.
- i_col_valid  input  NUM_COL  bit c = o_valid_down of bottom PE in column c.
- i_col_data  input  NUM_COL*SA_OUT_DATA_WIDTH  slice c = o_data_down of bottom PE in column c.
- o_wr_valid  output  1  a complete row is available.
- i_wr_ready  input  1  consumer accepts the row this cycle.
- o_wr_data  output  NUM_COL*SA_OUT_DATA_WIDTH  slice c = result of column c.
- o_wr_row  output  $clog2(NUM_ROW)  array row index of the current o_wr_data.
- o_wr_last  output  1  current beat is the final row of the tile.
- o_busy  output  1  armed, tile not yet fully drained.
- o_done  output  1  one-cycle pulse after the final beat is accepted.
- o_overflow  output  1  sticky error: a column push was dropped.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All FIFOs emptied; counters cleared.
  - o_wr_valid=0, o_wr_data=0, o_wr_row=NUM_ROW-1, o_wr_last=0, o_busy=0, o_done=0, o_overflow=0.
  - Reset mid-flush abandons the tile; any data in flight is discarded.
- Idle (o_busy=0): i_col_valid is ignored and nothing is pushed.
- i_start:
  - Sets o_busy=1 on the next cycle.
  - Empties all FIFOs and clears o_overflow, the per-column push counters and the row counter (o_wr_row=NUM_ROW-1).
  - i_start while busy behaves the same way (abort and re-arm).
- Capture, while busy:
  - Column c pushes i_col_data slice c in every cycle i_col_valid[c]=1 and its push counter is below NUM_ROW.
  - Pushes beyond NUM_ROW per column are ignored and do not set overflow.
  - Push to a full FIFO with no pop in the same cycle: data dropped, o_overflow set until the next i_start or rst.
  - Push and pop in the same cycle on a full FIFO is legal; occupancy is unchanged.
- Row order:
  - The bottom PE emits its own result first, then the results of the rows above in turn.
  - The first beat is therefore array row NUM_ROW-1, and o_wr_row decrements per accepted beat down to 0.
- Output:
  - o_wr_valid is registered and asserted when every column FIFO is non-empty and the row counter has not finished.
  - Latency: o_wr_valid rises one cycle after the push that makes the last column non-empty.
  - A beat is accepted when o_wr_valid && i_wr_ready. On acceptance all FIFOs pop together.
  - o_wr_data, o_wr_row and o_wr_last hold stable while o_wr_valid=1 and i_wr_ready=0.
  - With i_wr_ready held high, one beat is issued per cycle (full throughput).
  - Data passes through unmodified; no width change.
- Completion:
  - o_wr_last=1 exactly when o_wr_row==0 and o_wr_valid=1.
  - On acceptance of the last beat: o_done pulses on the next cycle, o_busy falls on that same cycle, and o_wr_valid deasserts.
- Backpressure: the array cannot be stalled. Sustained i_wr_ready=0 longer than the FIFO slack results in overflow.

Decomposition:
- Shared package (sa_pkg):
  - SA_OUT_DATA_WIDTH default.
  - Row-index width function (clog2 wrapper).
  - Flush command encoding constants shared with the PE: CMD_ACCUM=2'b01, CMD_FLUSH=2'b10.
- Sub-module drain_col_fifo: synchronous FIFO, one per column, generated NUM_COL times.
  - Ports: clk, rst, clr, push, din, pop, dout, empty, full.
  - Show-ahead read.
- Top level holds:
  - the arming and completion FSM, with states IDLE, DRAIN and DONE (DONE lasts one cycle, then returns to IDLE);
  - per-column push counters;
  - the row counter;
  - the output register stage.

Test Plan:
- Nominal flush:
  - Stimulus: i_start, then column c valid for 4 cycles starting at cycle c, with data = 100*c + r (r = 3..0 in emission order); i_wr_ready=1.
  - Required response: 4 beats, rows 3,2,1,0; beat row 3 = {303,203,103,3}; o_wr_last on row 0; o_done one cycle after; o_overflow=0.
- Backpressure:
  - Stimulus: same as nominal, with i_wr_ready=0 for 6 cycles after the first o_wr_valid.
  - Required response: o_wr_data stable throughout the stall; all 4 rows delivered in order; no overflow (FIFO_DEPTH=8).
- Overflow:
  - Stimulus: FIFO_DEPTH=4, NUM_ROW=8, i_wr_ready=0 throughout.
  - Required response: o_overflow=1 on the cycle after the 5th push into column 0; stays set; cleared by the next i_start.
- Not armed:
  - Stimulus: i_col_valid=4'hF for 10 cycles with no i_start.
  - Required response: o_wr_valid never asserts, o_busy=0.
- Abort and re-arm:
  - Stimulus: i_start mid-flush after 2 beats, followed by a fresh nominal flush.
  - Required response: stale data is discarded; new tile delivers rows 3..0 with the new data only.
- Reset mid-drain:
  - Stimulus: rst=1 for 1 cycle while o_wr_valid=1.
  - Required response: the next cycle shows all outputs at their reset values, FIFOs empty, o_wr_row=NUM_ROW-1.

Source files
------------

// File: rtl/systolic_array_os_drain_pkg.sv
// Shared constants and types for the systolic array drain path.
// Also holds the flush command encoding used by the PE array.
package sa_pkg;

  localparam int SA_OUT_DATA_WIDTH = 32;

  localparam logic [1:0] CMD_ACCUM = 2'b01;
  localparam logic [1:0] CMD_FLUSH = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } drain_st_e;

  function automatic int row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_array_os_drain_if.sv
// Row write port from the drain collector to the output SRAM writer.
// One beat carries a full array row plus its row index.
interface systolic_array_os_drain_if #(
  parameter int NUM_COL = 4,
  parameter int DW      = sa_pkg::SA_OUT_DATA_WIDTH,
  parameter int RW      = 2
);

  logic                   o_wr_valid;
  logic                   i_wr_ready;
  logic [NUM_COL*DW-1:0]  o_wr_data;
  logic [RW-1:0]          o_wr_row;
  logic                   o_wr_last;

  modport master (
    output o_wr_valid,
    output o_wr_data,
    output o_wr_row,
    output o_wr_last,
    input  i_wr_ready
  );

  modport slave (
    input  o_wr_valid,
    input  o_wr_data,
    input  o_wr_row,
    input  o_wr_last,
    output i_wr_ready
  );

endinterface

// File: rtl/systolic_array_os_drain_col_fifo.sv
// Per-column show-ahead FIFO; head is visible on dout while non-empty.
// Push on a full FIFO is taken only when a pop frees a slot that cycle.
module drain_col_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  // Pointer and occupancy update; clear wins over any push/pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/systolic_array_os_drain.sv
// Collects skewed per-column flush streams and emits deskewed rows.
// Rows leave bottom-up: first beat is the last array row.
module systolic_array_os_drain #(
  parameter int NUM_COL           = 4,
  parameter int NUM_ROW           = 4,
  parameter int SA_OUT_DATA_WIDTH = sa_pkg::SA_OUT_DATA_WIDTH,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_start,
  input  logic [NUM_COL-1:0]                  i_col_valid,
  input  logic [NUM_COL*SA_OUT_DATA_WIDTH-1:0] i_col_data,
  systolic_array_os_drain_if.master           wr,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_overflow
);

  import sa_pkg::*;

  localparam int DW = SA_OUT_DATA_WIDTH;
  localparam int RW = row_w(NUM_ROW);
  localparam int PW = $clog2(NUM_ROW + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PW-1:0] PUSH_MAX = PW'(NUM_ROW);
  localparam logic [RW-1:0] ROW_TOP  = RW'(NUM_ROW - 1);

  drain_st_e            state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic [PW-1:0]        pcnt_q [NUM_COL];
  logic [PW-1:0]        pcnt_d [NUM_COL];
  logic [NUM_COL-1:0]   push_req, push_ok;
  logic [NUM_COL-1:0]   empty, full, avail_nxt;
  logic [CW-1:0]        count [NUM_COL];
  logic [NUM_COL*DW-1:0] head;
  logic                 busy, accept;

  assign busy   = (state_q == S_DRAIN);
  assign accept = valid_q && wr.i_wr_ready;

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    assign push_req[c] = busy && !i_start && i_col_valid[c]
                       && (pcnt_q[c] < PUSH_MAX);
    assign push_ok[c]  = push_req[c] && (!full[c] || accept);
    assign avail_nxt[c] = push_ok[c]
                        || (!empty[c] && !(accept && count[c] == CW'(1)));

    drain_col_fifo #(
      .W     (DW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (i_start),
      .push  (push_ok[c]),
      .din   (i_col_data[c*DW +: DW]),
      .pop   (accept),
      .dout  (head[c*DW +: DW]),
      .empty (empty[c]),
      .full  (full[c]),
      .count (count[c])
    );
  end

  // Arming/completion FSM, row index, overflow and next-cycle row valid.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    for (int c = 0; c < NUM_COL; c++) begin
      pcnt_d[c] = pcnt_q[c] + PW'(push_req[c]);
    end
    unique case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_DRAIN: if (accept && row_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept && row_q != '0) row_d = row_q - RW'(1);
    if (|(push_req & ~push_ok)) ovf_d = 1'b1;
    valid_d = (state_d == S_DRAIN) && (&avail_nxt);
    if (i_start) begin
      state_d = S_DRAIN;
      row_d   = ROW_TOP;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
      for (int c = 0; c < NUM_COL; c++) begin
        pcnt_d[c] = '0;
      end
    end
  end

  // Control and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= ROW_TOP;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int c = 0; c < NUM_COL; c++) begin
        pcnt_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      for (int c = 0; c < NUM_COL; c++) begin
        pcnt_q[c] <= pcnt_d[c];
      end
    end
  end

  assign wr.o_wr_valid = valid_q;
  assign wr.o_wr_data  = valid_q ? head : '0;
  assign wr.o_wr_row   = row_q;
  assign wr.o_wr_last  = valid_q && (row_q == '0);
  assign o_busy        = busy;
  assign o_done        = (state_q == S_DONE);
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_systolic_array_os_drain.sv
// Bench for the drain collector: row-level model plus directed checks.
// A second instance (depth 4, 8 rows) exercises overflow.
module tb_systolic_array_os_drain;

  localparam int NC  = 4;
  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int RW  = 2;
  localparam int RW2 = 3;

  logic clk = 1'b0;
  logic rst;
  logic i_start;
  logic [NC-1:0]   i_col_valid;
  logic [NC*W-1:0] i_col_data;
  logic o_busy, o_done, o_overflow;

  logic i_start2;
  logic [NC-1:0]   i_col_valid2;
  logic [NC*W-1:0] i_col_data2;
  logic o_busy2, o_done2, o_overflow2;

  systolic_array_os_drain_if #(.NUM_COL(NC), .DW(W), .RW(RW))  wr();
  systolic_array_os_drain_if #(.NUM_COL(NC), .DW(W), .RW(RW2)) wr2();

  systolic_array_os_drain dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_col_valid (i_col_valid),
    .i_col_data  (i_col_data),
    .wr          (wr),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_overflow  (o_overflow)
  );

  systolic_array_os_drain #(
    .NUM_ROW    (8),
    .FIFO_DEPTH (4)
  ) dut2 (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start2),
    .i_col_valid (i_col_valid2),
    .i_col_data  (i_col_data2),
    .wr          (wr2),
    .o_busy      (o_busy2),
    .o_done      (o_done2),
    .o_overflow  (o_overflow2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NC*W-1:0] data;
    int              row;
  } beat_t;

  beat_t exp_q[$];

  bit vq [64];
  bit lq [64];
  bit dq [64];
  bit bq [64];
  bit oq [64];
  int fv_k;
  logic [NC*W-1:0] fv_data;

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result emitted by column c for array row r of a tile.
  function automatic logic [W-1:0] val(input int tag, input int c,
                                       input int r);
    return W'(tag * 1000 + 100 * c + r);
  endfunction

  // A tile is delivered as rows NR-1 down to 0, each row gathering
  // the result for that row from every column.
  task automatic expect_tile(input int tag);
    for (int r = NR - 1; r >= 0; r--) begin
      beat_t b;
      for (int c = 0; c < NC; c++) b.data[c*W +: W] = val(tag, c, r);
      b.row = r;
      exp_q.push_back(b);
    end
  endtask

  // Compare process: every accepted beat against the model queue,
  // plus hold-stability while stalled.
  logic [NC*W-1:0] hold_data;
  int              hold_row;
  bit              hold_pend = 1'b0;
  always @(negedge clk) begin
    beat_t b;
    if (hold_pend) begin
      chk("stall_data", wr.o_wr_data, hold_data);
      chk("stall_row", 128'(wr.o_wr_row), 128'(hold_row));
    end
    hold_pend = wr.o_wr_valid && !wr.i_wr_ready && !rst && !i_start;
    hold_data = wr.o_wr_data;
    hold_row  = int'(wr.o_wr_row);
    if (!wr.o_wr_valid) chk("idle_last", 128'(wr.o_wr_last), 128'(0));
    if (wr.o_wr_valid && wr.i_wr_ready && !rst && !i_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_beat got=row%0d exp=none", wr.o_wr_row);
      end else begin
        b = exp_q.pop_front();
        chk("beat_data", wr.o_wr_data, b.data);
        chk("beat_row", 128'(wr.o_wr_row), 128'(b.row));
        chk("beat_last", 128'(wr.o_wr_last), 128'(b.row == 0));
      end
    end
  end

  task automatic tile(input int tag, input int vlen, input int ncyc,
                      input int st_from, input int st_len,
                      output int ndone);
    ndone = 0;
    fv_k  = -1;
    exp_q.delete();
    expect_tile(tag);
    i_start        = 1'b1;
    i_col_valid    = '0;
    wr.i_wr_ready  = 1'b0;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      for (int c = 0; c < NC; c++) begin
        i_col_valid[c] = (k >= c) && (k < c + vlen);
        i_col_data[c*W +: W] = val(tag, c, NR - 1 - (k - c));
      end
      wr.i_wr_ready = !((k >= st_from) && (k < st_from + st_len));
      @(negedge clk);
      vq[k] = wr.o_wr_valid;
      lq[k] = wr.o_wr_last;
      dq[k] = o_done;
      bq[k] = o_busy;
      oq[k] = o_overflow;
      if (o_done) ndone++;
      if (wr.o_wr_valid && fv_k < 0) begin
        fv_k    = k;
        fv_data = wr.o_wr_data;
      end
      tick();
    end
    i_col_valid   = '0;
    wr.i_wr_ready = 1'b0;
  endtask

  task automatic reset_checks(input string tagname);
    chk({tagname, "_valid"}, 128'(wr.o_wr_valid), 128'(0));
    chk({tagname, "_data"}, wr.o_wr_data, 128'(0));
    chk({tagname, "_row"}, 128'(wr.o_wr_row), 128'(NR - 1));
    chk({tagname, "_last"}, 128'(wr.o_wr_last), 128'(0));
    chk({tagname, "_busy"}, 128'(o_busy), 128'(0));
    chk({tagname, "_done"}, 128'(o_done), 128'(0));
    chk({tagname, "_ovf"}, 128'(o_overflow), 128'(0));
  endtask

  initial begin
    int nd;
    rst            = 1'b1;
    i_start        = 1'b0;
    i_col_valid    = '0;
    i_col_data     = '0;
    wr.i_wr_ready  = 1'b0;
    i_start2       = 1'b0;
    i_col_valid2   = '0;
    i_col_data2    = '0;
    wr2.i_wr_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    reset_checks("rst");
    chk("rst_row2", 128'(wr2.o_wr_row), 128'(7));
    tick();

    // Not armed: valid columns are ignored.
    wr.i_wr_ready = 1'b1;
    i_col_valid   = 4'hF;
    for (int k = 0; k < 10; k++) begin
      i_col_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("idle_valid", 128'(wr.o_wr_valid), 128'(0));
      chk("idle_busy", 128'(o_busy), 128'(0));
      tick();
    end
    i_col_valid   = '0;
    wr.i_wr_ready = 1'b0;

    // Nominal flush, data = 100*c + r.
    tile(0, 4, 12, 99, 0, nd);
    chk("nom_latency", 128'(fv_k), 128'(4));
    chk("nom_pre_valid", 128'(vq[3]), 128'(0));
    chk("nom_first_beat", fv_data,
        {32'd303, 32'd203, 32'd103, 32'd3});
    chk("nom_last_r0", 128'(lq[7]), 128'(1));
    chk("nom_last_r1", 128'(lq[6]), 128'(0));
    chk("nom_busy_k7", 128'(bq[7]), 128'(1));
    chk("nom_done_k7", 128'(dq[7]), 128'(0));
    chk("nom_done_k8", 128'(dq[8]), 128'(1));
    chk("nom_busy_k8", 128'(bq[8]), 128'(0));
    chk("nom_valid_k8", 128'(vq[8]), 128'(0));
    chk("nom_done_cnt", 128'(nd), 128'(1));
    chk("nom_ovf", 128'(oq[11]), 128'(0));
    chk("nom_rows_left", 128'(exp_q.size()), 128'(0));

    // Backpressure: ready low for 6 cycles from first valid.
    tile(5, 4, 20, 4, 6, nd);
    chk("bp_latency", 128'(fv_k), 128'(4));
    chk("bp_held", 128'(vq[9]), 128'(1));
    chk("bp_done_k14", 128'(dq[14]), 128'(1));
    chk("bp_done_cnt", 128'(nd), 128'(1));
    chk("bp_ovf", 128'(oq[19]), 128'(0));
    chk("bp_rows_left", 128'(exp_q.size()), 128'(0));

    // Abort after two beats, then re-arm with fresh data; the new
    // tile also offers a fifth push per column that must be ignored.
    tile(6, 4, 6, 99, 0, nd);
    chk("abort_rows_left", 128'(exp_q.size()), 128'(2));
    tile(7, 5, 14, 99, 0, nd);
    chk("rearm_rows_left", 128'(exp_q.size()), 128'(0));
    chk("rearm_done_cnt", 128'(nd), 128'(1));
    chk("rearm_ovf", 128'(oq[13]), 128'(0));

    // Reset while a row is pending.
    tile(8, 4, 6, 4, 10, nd);
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid", 128'(wr.o_wr_valid), 128'(1));
    tick();
    rst = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    tick();
    tile(9, 4, 12, 99, 0, nd);
    chk("post_rst_rows_left", 128'(exp_q.size()), 128'(0));
    chk("post_rst_done_cnt", 128'(nd), 128'(1));

    // Overflow on depth-4 / 8-row instance with no consumer.
    i_start2 = 1'b1;
    tick();
    i_start2 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < NC; c++) begin
        i_col_valid2[c] = (k >= c) && (k < c + 8);
        i_col_data2[c*W +: W] = W'(100 * c + k);
      end
      @(negedge clk);
      oq[k] = o_overflow2;
      if (k == 4) begin
        chk("ovf2_valid_k4", 128'(wr2.o_wr_valid), 128'(1));
        chk("ovf2_row_k4", 128'(wr2.o_wr_row), 128'(7));
      end
      tick();
    end
    chk("ovf2_k4", 128'(oq[4]), 128'(0));
    chk("ovf2_k5", 128'(oq[5]), 128'(1));
    chk("ovf2_sticky", 128'(oq[15]), 128'(1));
    i_col_valid2 = '0;
    i_start2     = 1'b1;
    tick();
    i_start2 = 1'b0;
    @(negedge clk);
    chk("ovf2_cleared", 128'(o_overflow2), 128'(0));
    chk("ovf2_busy", 128'(o_busy2), 128'(1));
    chk("ovf2_valid_clr", 128'(wr2.o_wr_valid), 128'(0));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
